// File: rtl/sc_dmem_arbiter.sv
// sc_dmem_arbiter: shares the single data-memory port between the
// single-cycle CPU (primary, priority) and one secondary requester.
// A starvation counter forces the port over to the secondary after
// MAX_WAIT lost cycles. In that cycle cpu_stall is raised so the CPU
// replays its load/store on the next cycle.
//
// Ports:
//   clock, resetn         rising-edge clock, async active-low reset
//   cpu_*                 CPU data access (addr/wdata/wmem/rmem in, rdata/stall out)
//   sec_req/we/addr/wdata secondary request, level, held until sec_ack
//   sec_gnt               secondary owns the port this cycle
//   sec_ack, sec_rdata    one-cycle completion pulse and captured read data
//   mem_*                 data memory port (rdata is valid in the same cycle)
module sc_dmem_arbiter #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_wmem,
  input  logic        cpu_rmem,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        sec_req,
  input  logic        sec_we,
  input  logic [31:0] sec_addr,
  input  logic [31:0] sec_wdata,
  output logic        sec_gnt,
  output logic        sec_ack,
  output logic [31:0] sec_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             req_we;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             forced;
  logic             grant;

  // Forced steal depends only on state and counter, so cpu_stall never
  // loops back through the CPU's own memory-enable decode.
  assign forced = (state == WAIT) && (wait_cnt == MAX_CNT);
  assign grant  = (state == WAIT) && ((!cpu_wmem && !cpu_rmem) || forced);

  assign sec_gnt   = grant;
  assign cpu_stall = forced;
  assign cpu_rdata = mem_rdata;

  // In a granted cycle the CPU store is dropped entirely; a stalled store
  // is replayed next cycle, so it must not land now.
  assign mem_addr  = grant ? req_addr  : cpu_addr;
  assign mem_wdata = grant ? req_wdata : cpu_wdata;
  assign mem_we    = grant ? req_we    : cpu_wmem;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      sec_ack   <= 1'b0;
      sec_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          sec_ack <= 1'b0;
          if (sec_req) begin
            // Request is latched here; later changes on sec_* are ignored.
            req_we    <= sec_we;
            req_addr  <= sec_addr;
            req_wdata <= sec_wdata;
            wait_cnt  <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (grant) begin
            sec_rdata <= mem_rdata;
            sec_ack   <= 1'b1;
            state     <= ACK;
          end else if (wait_cnt != MAX_CNT) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ACK: begin
          // sec_req is ignored here; a still-high request restarts from IDLE.
          sec_ack <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          sec_ack <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
module tb_sc_dmem_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_wmem, cpu_rmem, cpu_stall;
  logic        sec_req, sec_we, sec_gnt, sec_ack;
  logic [31:0] sec_addr, sec_wdata, sec_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  always #5 clock = ~clock;

  sc_dmem_arbiter #(.MAX_WAIT(15), .CNT_W(4)) dut (
    .clock(clock), .resetn(resetn),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmem(cpu_wmem),
    .cpu_rmem(cpu_rmem), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .sec_req(sec_req), .sec_we(sec_we), .sec_addr(sec_addr),
    .sec_wdata(sec_wdata), .sec_gnt(sec_gnt), .sec_ack(sec_ack),
    .sec_rdata(sec_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Data memory model: combinational read, write on the clock edge.
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clock) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  int checks = 0;
  int errors = 0;
  int ack_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: expectation pushed at launch, popped on sec_ack.
  typedef struct {
    logic        we;
    logic [31:0] rdata;
  } sb_t;
  sb_t sb[$];
  sb_t sb_e;

  always @(negedge clock) begin
    if (resetn && sec_ack) begin
      ack_count++;
      if (sb.size() == 0) chk("spurious_ack", 32'd1, 32'd0);
      else begin
        sb_e = sb.pop_front();
        if (!sb_e.we) chk("sec_rdata", sec_rdata, sb_e.rdata);
      end
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          busy;       // WAIT cycles in which the CPU is loading/storing
    int          exp_gnt;    // cycle of sec_gnt, cycle 1 = IDLE latch cycle
    logic        exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t tbl[5];

  task automatic cpu_idle();
    cpu_wmem = 0; cpu_rmem = 0; cpu_addr = 32'h100; cpu_wdata = 32'h0;
  endtask

  // CPU traffic for WAIT cycle k: loads of 0x0 / stores to 0x20, and a
  // store of 5 to 0x10 in the cycle where the port gets stolen.
  task automatic cpu_op(input int k, input int busy);
    if (k < busy) begin
      if (k == 15) begin
        cpu_wmem = 1; cpu_rmem = 0; cpu_addr = 32'h10; cpu_wdata = 32'd5;
      end else if (k % 2 == 1) begin
        cpu_wmem = 1; cpu_rmem = 0; cpu_addr = 32'h20; cpu_wdata = 32'(k);
      end else begin
        cpu_wmem = 0; cpu_rmem = 1; cpu_addr = 32'h0; cpu_wdata = 32'h0;
      end
    end else cpu_idle();
  endtask

  task automatic cpu_cycle(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    cpu_wmem = w; cpu_rmem = r; cpu_addr = a; cpu_wdata = d;
    @(negedge clock);
  endtask

  task automatic run_txn(input vec_t v);
    bit got = 0;
    sb_t e;
    @(posedge clock); #1;
    sec_req = 1; sec_we = v.we; sec_addr = v.addr; sec_wdata = v.wdata;
    cpu_idle();
    e.we = v.we; e.rdata = v.exp_rdata; sb.push_back(e);
    @(negedge clock);
    chk("idle_no_gnt", 32'(sec_gnt), 32'd0);
    for (int c = 2; c <= 25 && !got; c++) begin
      @(posedge clock); #1;
      // Scramble the request fields after the latch.
      sec_we = ~v.we; sec_addr = 32'hFFFF_FFFC; sec_wdata = 32'hBAD0_0000 | 32'(c);
      cpu_op(c - 2, v.busy);
      @(negedge clock);
      if (sec_gnt) begin
        got = 1;
        chk("gnt_cycle", 32'(c), 32'(v.exp_gnt));
        chk("gnt_stall", 32'(cpu_stall), 32'(v.exp_stall));
        chk("gnt_mem_we", 32'(mem_we), 32'(v.we));
        chk("gnt_mem_addr", mem_addr, v.addr);
        if (v.we) chk("gnt_mem_wdata", mem_wdata, v.wdata);
      end else if (cpu_stall) chk("stall_without_gnt", 32'd1, 32'd0);
    end
    if (!got) chk("gnt_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    sec_req = 0; cpu_idle();
    @(negedge clock);
    chk("ack", 32'(sec_ack), 32'd1);
    chk("ack_no_stall", 32'(cpu_stall), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("ack_pulse", 32'(sec_ack), 32'd0);
  endtask

  initial begin
    int a1, a2, nacks, acks_before;
    tbl[0] = '{we: 1, addr: 32'h40, wdata: 32'hDEADBEEF, busy: 0,  exp_gnt: 2,  exp_stall: 0, exp_rdata: 32'h0};
    tbl[1] = '{we: 0, addr: 32'h40, wdata: 32'h0,        busy: 1,  exp_gnt: 3,  exp_stall: 0, exp_rdata: 32'hDEADBEEF};
    tbl[2] = '{we: 0, addr: 32'h40, wdata: 32'h0,        busy: 20, exp_gnt: 17, exp_stall: 1, exp_rdata: 32'hDEADBEEF};
    tbl[3] = '{we: 1, addr: 32'h80, wdata: 32'h12345678, busy: 15, exp_gnt: 17, exp_stall: 1, exp_rdata: 32'h0};
    tbl[4] = '{we: 0, addr: 32'h80, wdata: 32'h0,        busy: 14, exp_gnt: 16, exp_stall: 0, exp_rdata: 32'h12345678};

    resetn = 0; sec_req = 0; sec_we = 0; sec_addr = 0; sec_wdata = 0;
    cpu_idle();
    #2;
    chk("rst_sec_ack", 32'(sec_ack), 32'd0);
    chk("rst_sec_rdata", sec_rdata, 32'd0);
    chk("rst_sec_gnt", 32'(sec_gnt), 32'd0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("rst_mem_addr", mem_addr, cpu_addr);
    @(posedge clock); #1;
    resetn = 1;

    // Known contents for the untouchable locations.
    cpu_cycle(1, 0, 32'h10, 32'h11110000);
    cpu_cycle(1, 0, 32'h30, 32'h0C0FFEE0);
    cpu_cycle(0, 0, 32'h100, 32'h0);

    foreach (tbl[i]) run_txn(tbl[i]);

    cpu_cycle(0, 1, 32'h40, 32'h0);
    chk("cpu_load_0x40", cpu_rdata, 32'hDEADBEEF);
    cpu_cycle(0, 1, 32'h10, 32'h0);
    chk("steal_no_cpu_store", cpu_rdata, 32'h11110000);
    cpu_cycle(0, 1, 32'h80, 32'h0);
    chk("cpu_load_0x80", cpu_rdata, 32'h12345678);

    // Back-to-back: request held across the first ack.
    a1 = 0; a2 = 0; nacks = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock); #1;
      cpu_idle();
      if (c == 1) begin
        sec_req = 1; sec_we = 0; sec_addr = 32'h40;
        sb.push_back('{we: 0, rdata: 32'hDEADBEEF});
        sb.push_back('{we: 0, rdata: 32'hDEADBEEF});
      end
      if (nacks == 2) sec_req = 0;
      @(negedge clock);
      if (sec_ack) begin
        nacks++;
        if (nacks == 1) a1 = c; else a2 = c;
      end
    end
    sec_req = 0;
    chk("b2b_ack_count", 32'(nacks), 32'd2);
    chk("b2b_ack_gap", 32'(a2 - a1), 32'd3);

    // Reset while a write is pending in WAIT.
    sb.delete();
    @(posedge clock); #1;
    sec_req = 1; sec_we = 1; sec_addr = 32'h30; sec_wdata = 32'hBAD0BAD0;
    cpu_idle();
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      cpu_op(0, 1);
    end
    @(posedge clock); #1;
    cpu_idle();
    #1;
    chk("pre_rst_gnt", 32'(sec_gnt), 32'd1);
    acks_before = ack_count;
    resetn = 0; sec_req = 0;
    #1;
    chk("mid_rst_gnt", 32'(sec_gnt), 32'd0);
    chk("mid_rst_stall", 32'(cpu_stall), 32'd0);
    chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
    chk("mid_rst_mem_addr", mem_addr, cpu_addr);
    chk("mid_rst_sec_ack", 32'(sec_ack), 32'd0);
    chk("mid_rst_sec_rdata", sec_rdata, 32'd0);
    @(posedge clock); #1;
    resetn = 1;
    for (int k = 0; k < 4; k++) cpu_cycle(0, 0, 32'h100, 32'h0);
    chk("rst_no_ack", 32'(ack_count), 32'(acks_before));
    cpu_cycle(0, 1, 32'h30, 32'h0);
    chk("rst_no_write", cpu_rdata, 32'h0C0FFEE0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sc_dmem_arbiter.md
Name: sc_dmem_arbiter

Overview:
- Shares the single data-memory port between the single-cycle CPU (primary) and one secondary requester, such as a program loader or a display-refresh master.
- The CPU has priority. The secondary is served in cycles where the CPU performs no load or store.
- A starvation counter forces service. When it saturates, the arbiter asserts cpu_stall for one cycle and steals the port.
- Sits between sc_cpu and sc_datamem_io inside the computer top level.

Parameters:
- MAX_WAIT, 15: WAIT cycles lost to the CPU before a forced grant (1..2^CNT_W-1).
- CNT_W, 4: width of the starvation counter.

Ports:
- clock  in  1  system clock (the CPU clock); all state updates on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- cpu_addr  in  32  CPU data address (aluout).
- cpu_wdata  in  32  CPU store data.
- cpu_wmem  in  1  CPU store this cycle.
- cpu_rmem  in  1  CPU load this cycle.
- cpu_rdata  out  32  load data to CPU (mem_rdata passed through).
- cpu_stall  out  1  CPU must not commit this cycle (PC/regfile hold).
- sec_req  in  1  secondary request, level; held until sec_ack.
- sec_we  in  1  secondary write (1) / read (0).
- sec_addr  in  32  secondary address.
- sec_wdata  in  32  secondary write data.
- sec_gnt  out  1  port owned by secondary this cycle.
- sec_ack  out  1  one-cycle completion pulse.
- sec_rdata  out  32  read data, valid while sec_ack=1.
- mem_addr  out  32  to data memory.
- mem_wdata  out  32  to data memory.
- mem_we  out  1  to data memory.
- mem_rdata  in  32  from data memory; valid within the same clock cycle (memory runs on mem_clk).

Behaviour:
- Reset, asynchronous: state=IDLE, wait_cnt=0, latched request cleared, sec_ack=0, sec_rdata=0.
- Reset, combinational consequences: sec_gnt=0, cpu_stall=0, and mem_* follow the CPU.
- Reset mid-transaction aborts it: no write completes after reset assertion, and no ack is issued.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If sec_req=1, latch sec_we/sec_addr/sec_wdata, clear wait_cnt, go to WAIT.
  - The secondary is never granted in the IDLE cycle itself, so the minimum request-to-ack latency is 2 cycles.
- WAIT, grant condition: grant is asserted if cpu_wmem=0 and cpu_rmem=0 (free), or if wait_cnt==MAX_WAIT (forced).
- WAIT, grant cycle:
  - Outputs: sec_gnt=1; mem_addr/mem_wdata come from the latched request; mem_we = latched we.
  - cpu_stall=1 only in the forced case.
  - At the clock edge, sec_rdata<=mem_rdata (captured for reads too; don't-care for writes), sec_ack<=1, go to ACK.
- WAIT, no grant: the CPU owns the port and wait_cnt increments, saturating at MAX_WAIT.
- ACK:
  - sec_ack=1 for exactly this cycle; sec_req is ignored; return to IDLE.
  - The secondary may drop or re-raise sec_req. A still-high sec_req starts a new transaction from IDLE.
- Mux rule: when sec_gnt=0, mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_wmem.
- CPU write suppression: mem_we never carries cpu_wmem in a granted cycle. This guarantees that a forced steal cannot corrupt memory with a CPU store that will be replayed.
- cpu_rdata=mem_rdata always. In a forced cycle the CPU sees secondary data but is stalled, so the data is harmless.
- cpu_stall is combinational, depends only on the state and wait_cnt, and is high for at most 1 cycle per transaction.
- Changes to sec_addr/sec_we/sec_wdata after the IDLE latch have no effect.
- Only one outstanding secondary transaction is allowed. Secondary fairness: the worst-case request-to-ack latency is MAX_WAIT+2 cycles.

Test Plan:
- Idle CPU, secondary write: sec_req, sec_we=1, addr 0x40, data 0xDEADBEEF. Required: sec_gnt in cycle 2, mem_we=1 with addr 0x40, sec_ack in cycle 3; a later CPU load of 0x40 returns 0xDEADBEEF.
- Read while CPU busy one cycle: a CPU load is active in the first WAIT cycle and the CPU is idle in the next. Required: sec_gnt is delayed 1 cycle, then sec_ack with sec_rdata equal to the memory word.
- Starvation: the CPU issues loads/stores every cycle and the secondary reads. Required: exactly 15 denied WAIT cycles, then sec_gnt=1 and cpu_stall=1 together for one cycle, then sec_ack; cpu_stall is never high again for that request.
- Forced grant during a CPU store: cpu_wmem=1 to 0x10 with value 5 in the steal cycle. Required: mem_we follows the secondary request (0 for a read), and memory at 0x10 is unchanged.
- Back-to-back: sec_req held high across the ack. Required: a second transaction is launched, sec_ack pulses 1 cycle each, and there are at least 2 cycles between acks.
- Reset asserted in WAIT with a pending write. Required: outputs go to reset values immediately, no memory write occurs, and no sec_ack is issued.
